// File: rtl/core_pkg.sv
// core_pkg: load funct3 encodings and writeback FSM states shared by the core.
package core_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic {IDLE, WAIT_MEM} wb_state_t;
endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: exe handoff, data-memory return and regfile write signals of the writeback stage.
interface wb_unit_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic                  exe_valid;
    logic                  exe_ready;
    logic [ADDR_WIDTH-1:0] exe_rd_addr;
    logic                  exe_rd_wen;
    logic [DATA_WIDTH-1:0] exe_result;
    logic                  exe_is_load;
    logic [2:0]            exe_funct3;
    logic [1:0]            exe_addr_lo;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_wen;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  load_err;
    modport slave (
        input  exe_valid, exe_rd_addr, exe_rd_wen, exe_result, exe_is_load, exe_funct3, exe_addr_lo,
        input  mem_rvalid, mem_rdata,
        output exe_ready, rd_data, rd_addr, rd_wen, pend_valid, pend_addr, load_err
    );
    modport master (
        output exe_valid, exe_rd_addr, exe_rd_wen, exe_result, exe_is_load, exe_funct3, exe_addr_lo,
        output mem_rvalid, mem_rdata,
        input  exe_ready, rd_data, rd_addr, rd_wen, pend_valid, pend_addr, load_err
    );
endinterface

// File: rtl/load_ext.sv
// load_ext: picks the addressed byte/half out of a loaded word and sign/zero-extends it.
module load_ext
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  illegal
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        data = (funct3 == F3_LB)  ? {{(DATA_WIDTH-8){b[7]}}, b} :
               (funct3 == F3_LH)  ? {{(DATA_WIDTH-16){h[15]}}, h} :
               (funct3 == F3_LBU) ? {{(DATA_WIDTH-8){1'b0}}, b} :
               (funct3 == F3_LHU) ? {{(DATA_WIDTH-16){1'b0}}, h} : word;
        illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage; retires ALU results, waits for and extends load data, drives the regfile write port.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_unit
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    wb_unit_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);
    wb_state_t             state, next;
    logic [ADDR_WIDTH-1:0] cap_rd;
    logic                  cap_wen;
    logic [2:0]            cap_f3;
    logic [1:0]            cap_lo;
    logic [DATA_WIDTH-1:0] ext;
    logic                  illegal;
    logic                  accept, done_alu, done_ld;

    assign bus.exe_ready  = state == IDLE;
    assign accept         = bus.exe_valid & bus.exe_ready;
    assign done_alu       = accept & ~bus.exe_is_load;
    assign done_ld        = (state == WAIT_MEM) & bus.mem_rvalid;
    assign bus.pend_valid = (state == WAIT_MEM) & cap_wen & (|cap_rd);
    assign bus.pend_addr  = cap_rd;

    load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .funct3(cap_f3), .addr_lo(cap_lo), .word(bus.mem_rdata), .data(ext), .illegal(illegal)
    );

    always_comb begin
        next = state;
        next = (state == IDLE) ? ((accept & bus.exe_is_load) ? WAIT_MEM : IDLE)
                               : (bus.mem_rvalid ? IDLE : WAIT_MEM);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    // Writes to x0 or with wen clear still update addr/data, only the enable is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_rd       <= '0;
            cap_wen      <= 1'b0;
            cap_f3       <= '0;
            cap_lo       <= '0;
            bus.rd_data  <= '0;
            bus.rd_addr  <= '0;
            bus.rd_wen   <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.rd_wen   <= 1'b0;
            bus.load_err <= 1'b0;
            if (done_alu) begin
                bus.rd_addr <= bus.exe_rd_addr;
                bus.rd_data <= bus.exe_result;
                bus.rd_wen  <= bus.exe_rd_wen & (|bus.exe_rd_addr);
            end
            if (accept & bus.exe_is_load) begin
                cap_rd  <= bus.exe_rd_addr;
                cap_wen <= bus.exe_rd_wen;
                cap_f3  <= bus.exe_funct3;
                cap_lo  <= bus.exe_addr_lo;
            end
            if (done_ld) begin
                bus.rd_addr  <= cap_rd;
                bus.rd_data  <= ext;
                bus.rd_wen   <= cap_wen & (|cap_rd);
                bus.load_err <= illegal;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) retire_cnt <= '0;
        else     retire_cnt <= retire_cnt + 64'(done_alu | done_ld);
`endif
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed and randomized writeback traffic checked against a behavioural load/writeback model.
module tb_wb_unit;
    import core_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    longint unsigned exp_ret = 0;

    wb_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    wb_unit dut (.clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt));
`else
    wb_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        int unsigned bv;
        int unsigned hv;
        bv = (w >> (8 * int'(lo))) & 32'hFF;
        hv = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return bv >= 128 ? bv - 256 : bv;
            3'd1:    return hv >= 32768 ? hv - 65536 : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [2:0] f3);
        return f3 == 3'd3 || f3 >= 3'd6;
    endfunction

    task automatic alu(input logic [4:0] rd, input logic wen, input logic [31:0] d);
        check("alu_ready", bus.exe_ready, 1);
        bus.exe_valid   = 1;
        bus.exe_is_load = 0;
        bus.exe_rd_addr = rd;
        bus.exe_rd_wen  = wen;
        bus.exe_result  = d;
        bus.exe_funct3  = 3'($urandom);
        bus.exe_addr_lo = 2'($urandom);
        bus.mem_rvalid  = 1'($urandom);
        bus.mem_rdata   = $urandom;
        @(posedge clk); #1;
        bus.exe_valid  = 0;
        bus.mem_rvalid = 0;
        check("alu_wen", bus.rd_wen, wen && rd != 0);
        check("alu_addr", bus.rd_addr, rd);
        check("alu_data", bus.rd_data, d);
        check("alu_err", bus.load_err, 0);
        exp_ret++;
    endtask

    task automatic load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] w, input int dly);
        check("ld_ready", bus.exe_ready, 1);
        bus.exe_valid   = 1;
        bus.exe_is_load = 1;
        bus.exe_rd_addr = rd;
        bus.exe_rd_wen  = wen;
        bus.exe_result  = $urandom;
        bus.exe_funct3  = f3;
        bus.exe_addr_lo = lo;
        @(posedge clk); #1;
        for (int i = 0; i <= dly; i++) begin
            bus.exe_valid   = 1'($urandom);
            bus.exe_is_load = 0;
            bus.exe_rd_addr = 5'($urandom);
            bus.exe_funct3  = 3'($urandom);
            bus.exe_addr_lo = 2'($urandom);
            check("ld_busy", bus.exe_ready, 0);
            check("ld_pend_v", bus.pend_valid, wen && rd != 0);
            check("ld_pend_a", bus.pend_addr, rd);
            check("ld_nowen", bus.rd_wen, 0);
            if (i == dly) begin
                bus.mem_rvalid = 1;
                bus.mem_rdata  = w;
            end
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 0;
        bus.exe_valid  = 0;
        check("ld_wen", bus.rd_wen, wen && rd != 0);
        check("ld_addr", bus.rd_addr, rd);
        check("ld_data", bus.rd_data, ref_load(f3, lo, w));
        check("ld_err", bus.load_err, ref_illegal(f3));
        check("ld_ready_after", bus.exe_ready, 1);
        check("ld_pend_clr", bus.pend_valid, 0);
        check("ld_pend_hold", bus.pend_addr, rd);
        exp_ret++;
    endtask

    initial begin
        bus.exe_valid = 0; bus.exe_is_load = 0; bus.exe_rd_addr = 0; bus.exe_rd_wen = 0;
        bus.exe_result = 0; bus.exe_funct3 = 0; bus.exe_addr_lo = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0;
        #1 rst = 1;
        @(posedge clk); #1;
        check("rst_wen", bus.rd_wen, 0);
        check("rst_addr", bus.rd_addr, 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_pend_v", bus.pend_valid, 0);
        check("rst_pend_a", bus.pend_addr, 0);
        check("rst_err", bus.load_err, 0);
        check("rst_ready", bus.exe_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        // back-to-back ALU burst
        alu(5'd1, 1, 32'h11);
        alu(5'd2, 1, 32'h22);
        alu(5'd3, 1, 32'h33);
        load(5'd5, 1, F3_LB, 2'd3, 32'h80FF7F01, 3);
        load(5'd9, 1, F3_LHU, 2'd2, 32'h80011234, 1);
        load(5'd9, 1, F3_LH, 2'd2, 32'h80011234, 0);
        load(5'd9, 1, F3_LW, 2'd2, 32'h80011234, 2);
        alu(5'd0, 1, 32'hDEAD);
        load(5'd0, 1, F3_LW, 2'd0, 32'h12345678, 1);
        alu(5'd6, 0, 32'hBEEF);
        load(5'd4, 1, 3'b011, 2'd1, 32'hCAFEBABE, 0);
        load(5'd4, 1, 3'b111, 2'd3, 32'h0BADF00D, 1);
        repeat (80) begin
            if ($urandom_range(0, 1) == 0)
                alu(5'($urandom), $urandom_range(0, 3) != 0, $urandom);
            else
                load(5'($urandom), $urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom), $urandom,
                     int'($urandom_range(0, 4)));
        end
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, exp_ret);
`endif
        // reset while a load is outstanding, then a stray rvalid
        bus.exe_valid = 1; bus.exe_is_load = 1; bus.exe_rd_addr = 5'd7; bus.exe_rd_wen = 1;
        bus.exe_funct3 = F3_LW;
        @(posedge clk); #1;
        bus.exe_valid = 0;
        check("mid_pend", bus.pend_valid, 1);
        rst = 1;
        #2;
        check("async_ready", bus.exe_ready, 1);
        check("async_pend", bus.pend_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        bus.mem_rvalid = 0;
        check("stray_wen", bus.rd_wen, 0);
        check("stray_ready", bus.exe_ready, 1);
        check("stray_pend", bus.pend_valid, 0);
        check("stray_addr", bus.rd_addr, 0);
        @(posedge clk); #1;
        check("stray_wen2", bus.rd_wen, 0);
        exp_ret = 0;
        alu(5'd8, 1, 32'h5A5A5A5A);
`ifdef WB_RETIRE_CNT_EN
        check("retire_after_rst", retire_cnt, exp_ret);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
